// File: rtl/write_bytes_pkg.sv
// ============================================================================
// Module  : write_bytes_pkg
// Purpose : Shared types and helpers for the write_bytes engine: FSM state
//           encoding, byte/word widths and the little-endian byte selector.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package write_bytes_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Little-endian byte lane select: idx 0 is word[7:0].
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] w,
                                                 input logic [1:0]        idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/write_bytes.sv
// ============================================================================
// Module  : write_bytes
// Purpose : Byte-serial write engine. On start, splits a 32-bit word into
//           BYTES bytes and writes them little-endian (byte i -> addr+i,
//           wrapping modulo NUMBER) into a byte-wide synchronous RAM, one
//           byte per cycle. Optional read-back verify.
// Config  : WRITE_VERIFY_EN - when defined, a VERIFY phase reads the bytes
//           back and raises a sticky verify_err on any mismatch.
// Ports   : clk, reset (async, active-low)
//           start, addr, word        - request (sampled only in IDLE)
//           busy, done               - status
//           wr_clock, wr_en, wr_addr, wr_data - RAM write port
//           rd_addr, rd_data         - RAM read port (verify only)
//           verify_err               - sticky compare mismatch
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module write_bytes
  import write_bytes_pkg::*;
#(
  parameter  int NUMBER = 256,
  parameter  int BYTES  = 4,
  localparam int AW     = $clog2(NUMBER)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] word,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic              wr_en,
  output logic              wr_clock,
  output logic [AW-1:0]     rd_addr,
  input  logic [BYTE_W-1:0] rd_data,
  output logic              verify_err
);

  localparam logic [1:0] LAST = 2'(BYTES - 1);

  state_t            state;
  state_t            next_state;
  logic [1:0]        cnt;      // index of the byte currently on the write port
  logic [WORD_W-1:0] word_q;

  assign wr_clock = clk;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

`ifdef WRITE_VERIFY_EN
  logic [2:0] vcnt;
`endif

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:  if (start) next_state = WRITE;
      WRITE: begin
        if (cnt == LAST) begin
`ifdef WRITE_VERIFY_EN
          next_state = VERIFY;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef WRITE_VERIFY_EN
      VERIFY: if (vcnt == 3'(BYTES)) next_state = DONE;
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ----------------------------------------------------- write datapath
  // The write port is registered so wr_addr/wr_data hold their last values
  // outside WRITE; byte 0 is loaded on the accepting edge so the first RAM
  // write lands on the very next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      word_q  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            word_q  <= word;
            cnt     <= 2'd0;
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= byte_sel(word, 2'd0);
          end
        end
        WRITE: begin
          if (cnt == LAST) begin
            wr_en <= 1'b0;
          end else begin
            cnt     <= cnt + 2'd1;
            wr_addr <= wr_addr + 1'b1;  // AW-bit counter gives the modulo wrap
            wr_data <= byte_sel(word_q, cnt + 2'd1);
          end
        end
        default: wr_en <= 1'b0;
      endcase
    end
  end

  // ----------------------------------------------------------- verify
`ifdef WRITE_VERIFY_EN
  logic [AW-1:0]     base;
  logic [AW-1:0]     rd_q;
  logic [BYTE_W-1:0] exp_q;   // expected byte, delayed to line up with rd_data
  logic              err_q;

  // VERIFY cycle j presents address base+j (j < BYTES) and compares the
  // read data of address j-1 (j >= 1), hence BYTES+1 cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base  <= '0;
      rd_q  <= '0;
      exp_q <= '0;
      err_q <= 1'b0;
      vcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base  <= addr;
            err_q <= 1'b0;
          end
        end
        WRITE: begin
          if (cnt == LAST) begin
            rd_q <= base;
            vcnt <= '0;
          end
        end
        VERIFY: begin
          if (vcnt != 3'd0 && rd_data != exp_q) err_q <= 1'b1;
          exp_q <= byte_sel(word_q, vcnt[1:0]);
          if (vcnt < 3'(BYTES - 1)) rd_q <= rd_q + 1'b1;
          vcnt  <= vcnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign rd_addr    = rd_q;
  assign verify_err = err_q;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^rd_data;
  assign rd_addr        = '0;
  assign verify_err     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_write_bytes.sv
// ============================================================================
// Module  : tb_write_bytes
// Purpose : Self-checking bench for write_bytes with a byte RAM model and a
//           behavioural reference memory. Honors WRITE_VERIFY_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_write_bytes;

  localparam int NUMBER = 256;
  localparam int BYTES  = 4;
  localparam int AW     = 8;
`ifdef WRITE_VERIFY_EN
  localparam int EXP_LAT = 2 * BYTES + 2;
`else
  localparam int EXP_LAT = BYTES + 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   word = '0;
  logic          busy, done, wr_en, wr_clock, verify_err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    wr_data;
  logic [7:0]    rd_data;

  int vec = 0;
  int err = 0;

  logic [7:0] mem     [0:NUMBER-1];
  logic [7:0] ref_mem [0:NUMBER-1];
  logic       corrupt_en = 1'b0;
  logic [7:0] corrupt_addr = '0;

  always #5 clk = ~clk;

  write_bytes #(.NUMBER(NUMBER), .BYTES(BYTES)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .addr       (addr),
    .word       (word),
    .busy       (busy),
    .done       (done),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .wr_clock   (wr_clock),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .verify_err (verify_err)
  );

  // Byte-wide synchronous RAM; the read side can corrupt one address.
  always @(posedge wr_clock) if (wr_en) mem[wr_addr] <= wr_data;
  always @(posedge clk)
    rd_data <= (corrupt_en && rd_addr == corrupt_addr) ? ~mem[rd_addr] : mem[rd_addr];

  // Reference: little-endian bytes at consecutive addresses modulo NUMBER.
  task automatic model_write(input logic [7:0] a, input logic [31:0] w, input int nbytes);
    for (int i = 0; i < nbytes; i++)
      ref_mem[(int'(a) + i) % NUMBER] = 8'((w >> (8 * i)) & 32'hFF);
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < NUMBER; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Issues one start and watches the transfer for a bounded number of cycles.
  // Cycle c is the c-th clock period after the accepting edge.
  task automatic run_xfer(input logic [7:0] a, input logic [31:0] w,
                          input int inj_cycle, input logic [7:0] inj_a, input logic [31:0] inj_w,
                          output int lat, output int nwr, output int ndone,
                          output logic verr_done, output logic verr_c1,
                          output logic busy_c1, output logic busy_after);
    lat = -1; nwr = 0; ndone = 0;
    verr_done = 1'bx; verr_c1 = 1'bx; busy_c1 = 1'b0; busy_after = 1'b0;
    @(negedge clk);
    addr = a; word = w; start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == inj_cycle) begin addr = inj_a; word = inj_w; start = 1'b1; end
      if (c == 1) begin verr_c1 = verify_err; busy_c1 = busy; end
      if (wr_en) nwr++;
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = c; verr_done = verify_err; end
      end else if (lat >= 0 && busy) busy_after = 1'b1;
      if (lat >= 0 && c >= lat + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vec++;
    if ({busy, done, wr_en, verify_err, wr_addr, wr_data, rd_addr} !== '0) begin
      err++;
      $display("FAIL reset_state: got busy=%b done=%b wr_en=%b verr=%b wa=%h wd=%h ra=%h, required all 0",
               busy, done, wr_en, verify_err, wr_addr, wr_data, rd_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      err++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, nwr, nd; logic vd, v1, b1, ba;
    model_write(8'h37, 32'hDEADBEEF, BYTES);
    run_xfer(8'h37, 32'hDEADBEEF, 0, 8'h0, 32'h0, lat, nwr, nd, vd, v1, b1, ba);
    vec++;
    if (lat !== EXP_LAT || nwr !== BYTES || nd !== 1 || b1 !== 1'b1 || ba !== 1'b0) begin
      err++;
      $display("FAIL basic_timing: got lat=%0d wr=%0d done=%0d busy1=%b busy_after=%b, required %0d %0d 1 1 0",
               lat, nwr, nd, b1, ba, EXP_LAT, BYTES);
    end
    vec++;
    if ({mem[8'h37], mem[8'h38], mem[8'h39], mem[8'h3A]} !== 32'hEFBEADDE) begin
      err++;
      $display("FAIL basic_bytes: got %h%h%h%h, required efbeadde",
               mem[8'h37], mem[8'h38], mem[8'h39], mem[8'h3A]);
    end
    vec++;
    if (vd !== 1'b0) begin
      err++;
      $display("FAIL basic_verr: got %b, required 0", vd);
    end
  endtask

  task automatic test_wrap();
    int lat, nwr, nd; logic vd, v1, b1, ba;
    model_write(8'hFE, 32'h04030201, BYTES);
    run_xfer(8'hFE, 32'h04030201, 0, 8'h0, 32'h0, lat, nwr, nd, vd, v1, b1, ba);
    vec++;
    if ({mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]} !== 32'h01020304) begin
      err++;
      $display("FAIL wrap_bytes: got %h%h%h%h, required 01020304",
               mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]);
    end
    vec++;
    if (mem_diff() !== 0 || lat !== EXP_LAT) begin
      err++;
      $display("FAIL wrap_mem: got diff=%0d lat=%0d, required 0 %0d", mem_diff(), lat, EXP_LAT);
    end
  endtask

  task automatic test_readback();
    int lat, nwr, nd; logic vd, v1, b1, ba;
    logic [31:0] rb;
    model_write(8'h10, 32'h12345678, BYTES);
    run_xfer(8'h10, 32'h12345678, 0, 8'h0, 32'h0, lat, nwr, nd, vd, v1, b1, ba);
    rb = {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]};
    vec++;
    if (rb !== 32'h12345678) begin
      err++;
      $display("FAIL readback_word: got %h, required 12345678", rb);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, nwr, nd; logic vd, v1, b1, ba;
    model_write(8'h50, 32'hA1B2C3D4, BYTES);
    run_xfer(8'h50, 32'hA1B2C3D4, 2, 8'h90, 32'h55667788, lat, nwr, nd, vd, v1, b1, ba);
    vec++;
    if (nwr !== BYTES || nd !== 1 || lat !== EXP_LAT || mem_diff() !== 0) begin
      err++;
      $display("FAIL start_in_write: got wr=%0d done=%0d lat=%0d diff=%0d, required %0d 1 %0d 0",
               nwr, nd, lat, mem_diff(), BYTES, EXP_LAT);
    end
    model_write(8'h60, 32'h0BADF00D, BYTES);
    run_xfer(8'h60, 32'h0BADF00D, EXP_LAT, 8'hA0, 32'hCAFEBABE, lat, nwr, nd, vd, v1, b1, ba);
    vec++;
    if (ba !== 1'b0 || nd !== 1 || mem_diff() !== 0) begin
      err++;
      $display("FAIL start_in_done: got busy_after=%b done=%0d diff=%0d, required 0 1 0", ba, nd, mem_diff());
    end
  endtask

  task automatic test_random();
    int lat, nwr, nd; logic vd, v1, b1, ba;
    logic [7:0] a; logic [31:0] w;
    for (int t = 0; t < 16; t++) begin
      a = 8'($urandom_range(0, NUMBER - 1));
      w = $urandom;
      model_write(a, w, BYTES);
      run_xfer(a, w, 0, 8'h0, 32'h0, lat, nwr, nd, vd, v1, b1, ba);
      vec++;
      if (lat !== EXP_LAT || nwr !== BYTES || nd !== 1 || mem_diff() !== 0) begin
        err++;
        $display("FAIL random_%0d: addr=%h word=%h got lat=%0d wr=%0d done=%0d diff=%0d, required %0d %0d 1 0",
                 t, a, w, lat, nwr, nd, mem_diff(), EXP_LAT, BYTES);
      end
`ifdef WRITE_VERIFY_EN
      vec++;
      if (vd !== 1'b0 || rd_addr !== 8'(int'(a) + BYTES - 1)) begin
        err++;
        $display("FAIL random_verify_%0d: got verr=%b rd_addr=%h, required 0 %h",
                 t, vd, rd_addr, 8'(int'(a) + BYTES - 1));
      end
`else
      vec++;
      if (verify_err !== 1'b0 || rd_addr !== 8'h00) begin
        err++;
        $display("FAIL random_noverify_%0d: got verr=%b rd_addr=%h, required 0 00", t, verify_err, rd_addr);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    logic [31:0] w;
    w = $urandom;
    model_write(8'h80, w, 2);   // only bytes 0 and 1 reach the RAM
    @(negedge clk);
    addr = 8'h80; word = w; start = 1'b1;
    @(negedge clk);             // cycle 1: byte 0 on the port
    start = 1'b0;
    @(negedge clk);             // cycle 2: byte 1 on the port
    @(negedge clk);             // cycle 3: byte 2 on the port
    reset = 1'b0;
    #1;
    vec++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      err++;
      $display("FAIL reset_mid_stop: got wr_en=%b busy=%b, required 0 0", wr_en, busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    vec++;
    if (nd !== 0 || mem_diff() !== 0) begin
      err++;
      $display("FAIL reset_mid_result: got done_pulses=%0d diff=%0d, required 0 0", nd, mem_diff());
    end
  endtask

`ifdef WRITE_VERIFY_EN
  task automatic test_verify();
    int lat, nwr, nd; logic vd, v1, b1, ba;
    corrupt_addr = 8'h22;       // byte 2 of a transfer at 8'h20
    corrupt_en   = 1'b1;
    model_write(8'h20, 32'h89ABCDEF, BYTES);
    run_xfer(8'h20, 32'h89ABCDEF, 0, 8'h0, 32'h0, lat, nwr, nd, vd, v1, b1, ba);
    vec++;
    if (vd !== 1'b1 || verify_err !== 1'b1 || lat !== EXP_LAT) begin
      err++;
      $display("FAIL verify_detect: got verr_done=%b verr_after=%b lat=%0d, required 1 1 %0d",
               vd, verify_err, lat, EXP_LAT);
    end
    corrupt_en = 1'b0;
    model_write(8'h20, 32'h13579BDF, BYTES);
    run_xfer(8'h20, 32'h13579BDF, 0, 8'h0, 32'h0, lat, nwr, nd, vd, v1, b1, ba);
    vec++;
    if (v1 !== 1'b0 || vd !== 1'b0 || mem_diff() !== 0) begin
      err++;
      $display("FAIL verify_clear: got verr_c1=%b verr_done=%b diff=%0d, required 0 0 0", v1, vd, mem_diff());
    end
  endtask
`endif

  initial begin
    logic [7:0] v;
    for (int i = 0; i < NUMBER; i++) begin
      v = 8'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_readback();
    test_busy_ignore();
    test_random();
    test_reset_mid();
`ifdef WRITE_VERIFY_EN
    test_verify();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

`default_nettype wire
